// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for data_path.
// Runs instruction fetch (T0-T2), then decodes IR[31:27] in T3 and sequences
// the execute steps for 3-register ALU, neg/not, mul/div, nop and halt.
// Build option: define SINGLE_STEP_EN to add the Step input and a WAIT_S
// state that gates every entry into T0 on Step=1.
//
// state   | meaning
// --------+--------------------------------------------------------------
// RESET_S | held while clear is high; leaves to T0 on the first edge
// T0      | PC to MAR, Z <= PC+1
// T1      | PC <= Z, MDR <= mem[MAR]
// T2      | IR <= MDR
// T3      | decode; first execute step
// T4      | second operand / ALU operation
// T5      | write low result (Rin[Ra] or LO)
// T6      | write high result to HI (mul/div only)
// HALT    | stopped; only clear leaves
// WAIT_S  | single-step hold before T0 (SINGLE_STEP_EN only)

module control_sequencer #(
  parameter logic [4:0] NOP_OPCODE  = 5'b11010,
  parameter logic [4:0] HALT_OPCODE = 5'b11011
) (
  input  logic        Clock,
  input  logic        clear,
`ifdef SINGLE_STEP_EN
  input  logic        Step,
`endif
  input  logic [31:0] IR,
  output logic        Run,
  output logic        Illegal,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighin,
  output logic        Zlowin,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [4:0]  op
);

  typedef enum logic [3:0] {
    RESET_S,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    HALT
`ifdef SINGLE_STEP_EN
    ,
    WAIT_S
`endif
  } state_t;

  state_t state;
  state_t next_state;
  state_t after_last;

  logic [4:0] opc;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       is_halt;
  logic       is_nop;
  logic       is_alu;
  logic       is_neg;
  logic       is_md;
  logic       unused_ir;

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    onehot = 16'h0001 << idx;
  endfunction

  assign opc       = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  // NOP/HALT are matched first so an overridden opcode value still wins.
  assign is_halt = (opc == HALT_OPCODE);
  assign is_nop  = (opc == NOP_OPCODE) && !is_halt;
  assign is_alu  = (opc <= 5'd8) && !is_halt && !is_nop;
  assign is_neg  = ((opc == 5'd9) || (opc == 5'd10)) && !is_halt && !is_nop;
  assign is_md   = ((opc == 5'd11) || (opc == 5'd12)) && !is_halt && !is_nop;

  // Where the sequencer goes once an instruction (or reset) is finished.
`ifdef SINGLE_STEP_EN
  assign after_last = Step ? T0 : WAIT_S;
`else
  assign after_last = T0;
`endif

  // State register; clear drops straight into RESET_S, mid-instruction included.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) state <= RESET_S;
    else       state <= next_state;
  end

  // Next-state and strobe decode from the current state and IR.
  always_comb begin
    next_state = state;
    Run      = 1'b1;
    Illegal  = 1'b0;
    PCout    = 1'b0;
    MDRout   = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    ZHighin  = 1'b0;
    Zlowin   = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Rout     = 16'h0000;
    Rin      = 16'h0000;
    op       = 5'd0;
    unique case (state)
      RESET_S: begin
        Run        = 1'b0;
        next_state = after_last;
      end
      T0: begin
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zlowin     = 1'b1;
        next_state = T1;
      end
      T1: begin
        Zlowout    = 1'b1;
        PCin       = 1'b1;
        Read       = 1'b1;
        MDRin      = 1'b1;
        next_state = T2;
      end
      T2: begin
        MDRout     = 1'b1;
        IRin       = 1'b1;
        next_state = T3;
      end
      T3: begin
        if (is_halt) begin
          next_state = HALT;
        end else if (is_alu) begin
          Rout       = onehot(rb);
          Yin        = 1'b1;
          next_state = T4;
        end else if (is_neg) begin
          Rout       = onehot(rb);
          op         = opc;
          ZHighin    = 1'b1;
          Zlowin     = 1'b1;
          next_state = T5;
        end else if (is_md) begin
          Rout       = onehot(ra);
          Yin        = 1'b1;
          next_state = T4;
        end else begin
          // nop, and undefined opcodes treated as nop
          Illegal    = !is_nop;
          next_state = after_last;
        end
      end
      T4: begin
        Rout       = is_md ? onehot(rb) : onehot(rc);
        op         = opc;
        ZHighin    = 1'b1;
        Zlowin     = 1'b1;
        next_state = T5;
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_md) begin
          LOin       = 1'b1;
          next_state = T6;
        end else begin
          Rin        = onehot(ra);
          next_state = after_last;
        end
      end
      T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        next_state = after_last;
      end
      HALT: begin
        Run        = 1'b0;
        next_state = HALT;
      end
`ifdef SINGLE_STEP_EN
      WAIT_S: begin
        next_state = after_last;
      end
`endif
      default: begin
        Run        = 1'b0;
        next_state = RESET_S;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, ALU, neg, mul, nop, illegal,
// clear mid-instruction and halt, with hand-computed strobe patterns.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
`ifdef SINGLE_STEP_EN
  logic        Step = 1'b1;
`endif
  logic [31:0] IR = 32'h0;
  logic        Run, Illegal, PCout, MDRout, Zhighout, Zlowout, PCin, MARin, MDRin;
  logic        IRin, Yin, HIin, LOin, ZHighin, Zlowin, IncPC, Read;
  logic [15:0] Rout, Rin;
  logic [4:0]  op;

  int total = 0;
  int passed = 0;

  localparam logic [16:0] M_RUN   = 17'h10000;
  localparam logic [16:0] M_ILL   = 17'h08000;
  localparam logic [16:0] M_PCOUT = 17'h04000;
  localparam logic [16:0] M_MDROUT= 17'h02000;
  localparam logic [16:0] M_ZHOUT = 17'h01000;
  localparam logic [16:0] M_ZLOUT = 17'h00800;
  localparam logic [16:0] M_PCIN  = 17'h00400;
  localparam logic [16:0] M_MARIN = 17'h00200;
  localparam logic [16:0] M_MDRIN = 17'h00100;
  localparam logic [16:0] M_IRIN  = 17'h00080;
  localparam logic [16:0] M_YIN   = 17'h00040;
  localparam logic [16:0] M_HIIN  = 17'h00020;
  localparam logic [16:0] M_LOIN  = 17'h00010;
  localparam logic [16:0] M_ZHIN  = 17'h00008;
  localparam logic [16:0] M_ZLIN  = 17'h00004;
  localparam logic [16:0] M_INC   = 17'h00002;
  localparam logic [16:0] M_READ  = 17'h00001;

  logic [16:0] flags;
  assign flags = {Run, Illegal, PCout, MDRout, Zhighout, Zlowout, PCin, MARin, MDRin,
                  IRin, Yin, HIin, LOin, ZHighin, Zlowin, IncPC, Read};

  control_sequencer dut (
    .Clock(Clock), .clear(clear),
`ifdef SINGLE_STEP_EN
    .Step(Step),
`endif
    .IR(IR), .Run(Run), .Illegal(Illegal), .PCout(PCout), .MDRout(MDRout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin), .Zlowin(Zlowin),
    .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin), .op(op)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [16:0] ef, input logic [15:0] erout,
                         input logic [15:0] erin, input logic [4:0] eop);
    chk({tag, ".flags"}, {15'd0, flags}, {15'd0, ef});
    chk({tag, ".Rout"},  {16'd0, Rout},  {16'd0, erout});
    chk({tag, ".Rin"},   {16'd0, Rin},   {16'd0, erin});
    chk({tag, ".op"},    {27'd0, op},    {27'd0, eop});
  endtask

  // Checks T0..T2 at successive negedges; the new instruction word is
  // applied after T0 so the previous instruction's last step is undisturbed.
  task automatic fetch(input string tag, input logic [31:0] ir);
    @(negedge Clock);
    chk_all({tag, ".T0"}, M_RUN | M_PCOUT | M_MARIN | M_INC | M_ZLIN, 16'h0, 16'h0, 5'd0);
    IR = ir;
    @(negedge Clock);
    chk_all({tag, ".T1"}, M_RUN | M_ZLOUT | M_PCIN | M_READ | M_MDRIN, 16'h0, 16'h0, 5'd0);
    @(negedge Clock);
    chk_all({tag, ".T2"}, M_RUN | M_MDROUT | M_IRIN, 16'h0, 16'h0, 5'd0);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] o, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] c);
    mk = {o, a, b, c, 15'd0};
  endfunction

  initial begin
    IR = mk(5'b00011, 4'd1, 4'd2, 4'd3);
    #1;
    chk_all("reset.held", 17'h0, 16'h0, 16'h0, 5'd0);
    @(negedge Clock);
    chk_all("reset.held2", 17'h0, 16'h0, 16'h0, 5'd0);
    clear = 1'b0;
    #1;
    chk_all("reset.released", 17'h0, 16'h0, 16'h0, 5'd0);

    // 3-register ALU: add-type opc 00011, Ra=1 Rb=2 Rc=3
    fetch("alu", mk(5'b00011, 4'd1, 4'd2, 4'd3));
    @(negedge Clock); chk_all("alu.T3", M_RUN | M_YIN, 16'h0004, 16'h0, 5'd0);
    @(negedge Clock); chk_all("alu.T4", M_RUN | M_ZHIN | M_ZLIN, 16'h0008, 16'h0, 5'b00011);
    @(negedge Clock); chk_all("alu.T5", M_RUN | M_ZLOUT, 16'h0, 16'h0002, 5'd0);

    // neg: T4 skipped
    fetch("neg", mk(5'b01001, 4'd1, 4'd2, 4'd0));
    @(negedge Clock); chk_all("neg.T3", M_RUN | M_ZHIN | M_ZLIN, 16'h0004, 16'h0, 5'b01001);
    @(negedge Clock); chk_all("neg.T5", M_RUN | M_ZLOUT, 16'h0, 16'h0002, 5'd0);

    // mul: Ra=15, Rb=0
    fetch("mul", mk(5'b01011, 4'd15, 4'd0, 4'd0));
    @(negedge Clock); chk_all("mul.T3", M_RUN | M_YIN, 16'h8000, 16'h0, 5'd0);
    @(negedge Clock); chk_all("mul.T4", M_RUN | M_ZHIN | M_ZLIN, 16'h0001, 16'h0, 5'b01011);
    @(negedge Clock); chk_all("mul.T5", M_RUN | M_ZLOUT | M_LOIN, 16'h0, 16'h0, 5'd0);
    @(negedge Clock); chk_all("mul.T6", M_RUN | M_ZHOUT | M_HIIN, 16'h0, 16'h0, 5'd0);

    // undefined opcode
    fetch("ill", mk(5'b11111, 4'd3, 4'd4, 4'd5));
    @(negedge Clock); chk_all("ill.T3", M_RUN | M_ILL, 16'h0, 16'h0, 5'd0);

    // nop
    fetch("nop", mk(5'b11010, 4'd3, 4'd4, 4'd5));
    @(negedge Clock); chk_all("nop.T3", M_RUN, 16'h0, 16'h0, 5'd0);

    // div: Ra=4, Rb=9
    fetch("div", mk(5'b01100, 4'd4, 4'd9, 4'd0));
    @(negedge Clock); chk_all("div.T3", M_RUN | M_YIN, 16'h0010, 16'h0, 5'd0);
    @(negedge Clock); chk_all("div.T4", M_RUN | M_ZHIN | M_ZLIN, 16'h0200, 16'h0, 5'b01100);
    @(negedge Clock); chk_all("div.T5", M_RUN | M_ZLOUT | M_LOIN, 16'h0, 16'h0, 5'd0);
    @(negedge Clock); chk_all("div.T6", M_RUN | M_ZHOUT | M_HIIN, 16'h0, 16'h0, 5'd0);

    // clear during T4 of an ALU instruction
    fetch("clr", mk(5'b00000, 4'd6, 4'd7, 4'd8));
    @(negedge Clock); chk_all("clr.T3", M_RUN | M_YIN, 16'h0080, 16'h0, 5'd0);
    @(negedge Clock); chk_all("clr.T4", M_RUN | M_ZHIN | M_ZLIN, 16'h0100, 16'h0, 5'd0);
    #1 clear = 1'b1;
    #1 chk_all("clr.async", 17'h0, 16'h0, 16'h0, 5'd0);
    @(negedge Clock); chk_all("clr.held", 17'h0, 16'h0, 16'h0, 5'd0);
    clear = 1'b0;
    #1 chk_all("clr.reset_s", 17'h0, 16'h0, 16'h0, 5'd0);

    // restart: ALU opc 01000, Ra=0 Rb=15 Rc=7
    fetch("alu2", mk(5'b01000, 4'd0, 4'd15, 4'd7));
    @(negedge Clock); chk_all("alu2.T3", M_RUN | M_YIN, 16'h8000, 16'h0, 5'd0);
    @(negedge Clock); chk_all("alu2.T4", M_RUN | M_ZHIN | M_ZLIN, 16'h0080, 16'h0, 5'b01000);
    @(negedge Clock); chk_all("alu2.T5", M_RUN | M_ZLOUT, 16'h0, 16'h0001, 5'd0);

    // halt: absorbing
    fetch("halt", mk(5'b11011, 4'd0, 4'd0, 4'd0));
    @(negedge Clock); chk_all("halt.T3", M_RUN, 16'h0, 16'h0, 5'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      chk_all("halt.hold", 17'h0, 16'h0, 16'h0, 5'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
